// File: rtl/mem_param.sv
// Parametrised two-address synchronous RAM with registered read, write-first
// collision handling, range checking and an automatic post-reset clear.
module mem_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  init_done,
    output logic                  err
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    // One bit wider than an address so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH-1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr_ok, rd_ok;

    assign wr_ok = write && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok = read  && ({1'b0, rd_addr} < DEPTH_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        done_d  = done_q;
        we      = 1'b0;
        waddr   = wr_addr;
        wdata   = data_in;
        case (state_q)
            ST_INIT: begin
                // The clear sequence owns the write port; requests are only flagged.
                we    = 1'b1;
                waddr = cnt_q[ADDR_WIDTH-1:0];
                wdata = '0;
                cnt_d = cnt_q + 1'b1;
                err_d = write | read;
                if (cnt_q == LAST_W) begin
                    state_d = ST_READY;
                    done_d  = 1'b1;
                end
            end
            ST_READY: begin
                we    = wr_ok;
                err_d = (write && !wr_ok) || (read && !rd_ok);
                if (rd_ok) begin
                    valid_d = 1'b1;
                    data_d  = (wr_ok && (wr_addr == rd_addr)) ? data_in : mem_q[rd_addr];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET && we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign init_done = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_param.sv
// Scoreboard bench for mem_param: two instances (DEPTH 8 and DEPTH 6) share one
// stimulus stream; a word-level reference model predicts every output cycle.
module tb_mem_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [2:0] wa = '0, ra = '0;
    logic [5:0] din = '0;

    logic [5:0] dout8, dout6;
    logic       vld8, vld6, done8, done6, err8, err6;

    mem_param #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .DEPTH(8)) u_dut8 (
        .clk(clk), .RESET(rst), .write(wr), .wr_addr(wa), .data_in(din),
        .read(rd), .rd_addr(ra), .data_out(dout8), .valid_out(vld8),
        .init_done(done8), .err(err8)
    );

    mem_param #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .DEPTH(6)) u_dut6 (
        .clk(clk), .RESET(rst), .write(wr), .wr_addr(wa), .data_in(din),
        .read(rd), .rd_addr(ra), .data_out(dout6), .valid_out(vld6),
        .init_done(done6), .err(err6)
    );

    typedef struct packed {
        logic [5:0] data;
        logic       valid;
        logic       done;
        logic       err;
    } exp_t;

    exp_t q8[$];
    exp_t q6[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference state, one slot per instance.
    int         depth_m [2] = '{8, 6};
    logic [5:0] mm      [2][8];
    int         clr_left[2];
    bit         done_m  [2];
    bit         valid_m [2];
    bit         err_m   [2];
    logic [5:0] data_m  [2];

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic model(input int d, input bit r, input bit w, input logic [2:0] a_w,
                         input logic [5:0] di, input bit rq, input logic [2:0] a_r,
                         output exp_t e);
        bit wok, rok;
        if (r) begin
            // Every word is zero by the time requests are accepted again.
            for (int i = 0; i < 8; i++) mm[d][i] = '0;
            clr_left[d] = depth_m[d];
            done_m[d]   = 1'b0;
            valid_m[d]  = 1'b0;
            err_m[d]    = 1'b0;
            data_m[d]   = '0;
        end else if (!done_m[d]) begin
            clr_left[d]--;
            if (clr_left[d] == 0) done_m[d] = 1'b1;
            err_m[d]   = w | rq;
            valid_m[d] = 1'b0;
        end else begin
            wok = w  && (int'(a_w) < depth_m[d]);
            rok = rq && (int'(a_r) < depth_m[d]);
            err_m[d]   = (w && !wok) || (rq && !rok);
            valid_m[d] = rok;
            if (rok) data_m[d] = (wok && a_w == a_r) ? di : mm[d][a_r];
            if (wok) mm[d][a_w] = di;
        end
        e = '{data_m[d], valid_m[d], done_m[d], err_m[d]};
    endtask

    task automatic step(input bit r, input bit w, input logic [2:0] a_w, input logic [5:0] di,
                        input bit rq, input logic [2:0] a_r);
        exp_t e;
        @(negedge clk);
        rst = r; wr = w; wa = a_w; din = di; rd = rq; ra = a_r;
        model(0, r, w, a_w, di, rq, a_r, e);
        q8.push_back(e);
        model(1, r, w, a_w, di, rq, a_r, e);
        q6.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 6'd0, 0, 3'd0);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            cmp("d8.data_out",  {2'b0, dout8}, {2'b0, e.data});
            cmp("d8.valid_out", {7'b0, vld8},  {7'b0, e.valid});
            cmp("d8.init_done", {7'b0, done8}, {7'b0, e.done});
            cmp("d8.err",       {7'b0, err8},  {7'b0, e.err});
        end
        if (q6.size() > 0) begin
            e = q6.pop_front();
            cmp("d6.data_out",  {2'b0, dout6}, {2'b0, e.data});
            cmp("d6.valid_out", {7'b0, vld6},  {7'b0, e.valid});
            cmp("d6.init_done", {7'b0, done6}, {7'b0, e.done});
            cmp("d6.err",       {7'b0, err6},  {7'b0, e.err});
        end
    end

    initial begin
        logic [2:0] a, b;
        int         waited;

        // Clear sequence and read-back of zeros.
        step(1, 0, 3'd0, 6'd0, 0, 3'd0);
        step(1, 0, 3'd0, 6'd0, 0, 3'd0);
        idle(8);
        for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 6'd0, 1, 3'(i));
        idle(1);

        // Write/read sweep; afterwards data_out must hold.
        for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 6'(i + 1), 0, 3'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 6'd0, 1, 3'(i));
        idle(2);

        // Same-address collision, then independent write and read.
        step(0, 1, 3'd3, 6'h2A, 1, 3'd3);
        step(0, 1, 3'd1, 6'h11, 1, 3'd2);
        step(0, 0, 3'd0, 6'd0, 1, 3'd1);
        idle(1);

        // Out-of-range requests (only the DEPTH=6 instance rejects these).
        step(0, 1, 3'd7, 6'h15, 0, 3'd0);
        step(0, 0, 3'd0, 6'd0, 1, 3'd6);
        step(0, 1, 3'd6, 6'h22, 1, 3'd2);
        step(0, 0, 3'd0, 6'd0, 1, 3'd7);
        idle(1);

        // Requests while the clear is running.
        step(1, 0, 3'd0, 6'd0, 0, 3'd0);
        step(0, 1, 3'd0, 6'h3F, 1, 3'd0);
        idle(8);
        step(0, 0, 3'd0, 6'd0, 1, 3'd0);
        idle(1);

        // Reset during a read sweep and again during a clear.
        for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 6'(8 - i), 0, 3'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 3'd0, 6'd0, 1, 3'(i));
        step(1, 0, 3'd0, 6'd0, 1, 3'd4);
        idle(4);
        step(1, 0, 3'd0, 6'd0, 0, 3'd0);
        idle(8);
        for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 6'd0, 1, 3'(i));
        idle(1);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 500; n++) begin
            a = 3'($urandom_range(0, 7));
            b = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
            step($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)), a,
                 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), b);
        end
        idle(2);

        waited = 0;
        while ((q8.size() > 0 || q6.size() > 0) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (q8.size() > 0 || q6.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q8.size() + q6.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
